axi_r_burst_allocator: RTL and testbench
========================================

// Module: axi_r_burst_allocator
// PURPOSE
//   Read-data (R) allocator for one target (master-side) port of the AXI node. Merges R beats
//   from N_INIT_PORT slave-side ports into one R channel toward the master. Slave-side rvalid
//   arrives already routed to this port by the BR address decoder of each request block.
//   Grants a whole burst (locked until rlast) with round-robin fairness, through a 1-deep
//   full-throughput output register.
// PARAMETERS
//   AXI_DATA_W   64                      R data width
//   AXI_USER_W   6                       ruser width
//   N_INIT_PORT  5                       number of slave-side (initiator) ports merged, >=1
//   AXI_ID_IN    16                      master-side ID width
//   LOG_N_TARG   3                       target-index bits appended by the AW/AR allocators
//   AXI_ID_OUT   AXI_ID_IN+LOG_N_TARG    slave-side ID width
//   LOG_N_INIT   max(1,clog2(N_INIT_PORT)) width of grant index / rr pointer (derived)
// PORTS
//   clk      in   1                          clock, all state on rising edge
//   rst      in   1                          asynchronous reset, active-high
//   rid_i    in   [N_INIT_PORT][AXI_ID_OUT]  per-slave-port R ID (target index in MSBs)
//   rdata_i  in   [N_INIT_PORT][AXI_DATA_W]  per-slave-port R data
//   rresp_i  in   [N_INIT_PORT][2]           per-slave-port R response
//   rlast_i  in   [N_INIT_PORT]              last beat of burst
//   ruser_i  in   [N_INIT_PORT][AXI_USER_W]  user sideband
//   rvalid_i in   [N_INIT_PORT]              beat valid, already decoded for this port
//   rready_o out  [N_INIT_PORT]              beat accepted from that slave port
//   rid_o    out  AXI_ID_IN                  rid_i[g][AXI_ID_IN-1:0], target bits stripped
//   rdata_o  out  AXI_DATA_W                 registered R data
//   rresp_o  out  2                          registered R response
//   rlast_o  out  1                          registered last flag
//   ruser_o  out  AXI_USER_W                 registered user
//   rvalid_o out  1                          output register holds a beat
//   rready_i in   1                          master ready
// BEHAVIOUR
//   Reset (async, rst=1): state=IDLE, rr_ptr=0, grant=0, out_valid_q=0 -> rvalid_o=0; all
//     output payload regs 0; rready_o forced all-0 while rst=1.
//   Slot free: slot_free = ~out_valid_q | rready_i. accept = rvalid_i[g] & rready_o[g].
//   rready_o: one-hot or zero; only bit g may be 1, and only when slot_free.
//   IDLE: g = first port with rvalid_i=1 scanning rr_ptr, rr_ptr+1, ... wrapping at N_INIT_PORT-1
//     (combinational, same cycle). No rvalid_i -> rready_o=0, stay IDLE.
//     accept & rlast_i[g]  -> stay IDLE, rr_ptr <= (g+1) mod N_INIT_PORT.
//     accept & ~rlast_i[g] -> BURST, grant <= g (locked).
//   BURST: g = grant regardless of other rvalid_i; rvalid_i[g]=0 mid-burst -> wait, stay locked.
//     accept & rlast_i[g] -> IDLE, rr_ptr <= (grant+1) mod N_INIT_PORT.
//   Output register: on accept load payload, out_valid_q<=1; else if rready_i, out_valid_q<=0.
//     Latency 1 cycle accept->rvalid_o; sustains 1 beat/cycle with rready_i held 1.
//   rvalid_o held, payload stable while rvalid_o & ~rready_i (AXI rule); no beat lost/duplicated.
//   rvalid_i of non-granted ports may stay high indefinitely; never dropped, served in RR order.
//   Simultaneous: beat leaving (rready_i) and new beat loading in same cycle -> new beat loaded.
//   N_INIT_PORT=1: rr_ptr constant 0; lock still tracked.
//   rst mid-burst: burst abandoned, IDLE, output register emptied; no recovery of partial burst.
//   No arithmetic beyond mod-N pointer increment; ID truncation is a pure bit-select.
// TESTING
//   1 Reset: rst=1 with rvalid_i=5'b11111 -> rready_o=0, rvalid_o=0; release -> port0 granted first.
//   2 Burst lock: port1 4-beat burst, port3 valid from cycle 1 -> 4 port1 beats back-to-back on
//     rvalid_o cycles 1..4, then port3 granted; rready_o[3]=0 during port1 burst.
//   3 Round robin: ports 0,2,4 single-beat always valid -> grant order 0,2,4,0,2,4; rr_ptr wraps 4->0.
//   4 Backpressure: rready_i=0 for 3 cycles mid-burst -> rvalid_o=1, rdata_o stable, rready_o all 0;
//     on release 1 beat/cycle, beat count matches input exactly.
//   5 ID strip: rid_i[2]=19'h5_ABCD (AXI_ID_IN=16) -> rid_o=16'hABCD.
//   6 Reset mid-burst: assert rst on beat 2 of 8 -> rvalid_o=0 immediately, IDLE, rr_ptr=0 after release.

Source files
------------

// File: rtl/axi_r_burst_allocator.sv
// rtl/axi_r_burst_allocator.sv - R-channel allocator: burst-locked round-robin merge of slave-side R ports
// Output payload sits in a single register that can reload while the previous beat leaves.
module axi_r_burst_allocator #(
    parameter int AXI_DATA_W  = 64,
    parameter int AXI_USER_W  = 6,
    parameter int N_INIT_PORT = 5,
    parameter int AXI_ID_IN   = 16,
    parameter int LOG_N_TARG  = 3,
    parameter int AXI_ID_OUT  = AXI_ID_IN + LOG_N_TARG,
    parameter int LOG_N_INIT  = (N_INIT_PORT > 1) ? $clog2(N_INIT_PORT) : 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [N_INIT_PORT-1:0][AXI_ID_OUT-1:0] rid_i,
    input  logic [N_INIT_PORT-1:0][AXI_DATA_W-1:0] rdata_i,
    input  logic [N_INIT_PORT-1:0][1:0]            rresp_i,
    input  logic [N_INIT_PORT-1:0]                 rlast_i,
    input  logic [N_INIT_PORT-1:0][AXI_USER_W-1:0] ruser_i,
    input  logic [N_INIT_PORT-1:0]                 rvalid_i,
    output logic [N_INIT_PORT-1:0]                 rready_o,
    output logic [AXI_ID_IN-1:0]                   rid_o,
    output logic [AXI_DATA_W-1:0]                  rdata_o,
    output logic [1:0]                             rresp_o,
    output logic                                   rlast_o,
    output logic [AXI_USER_W-1:0]                  ruser_o,
    output logic                                   rvalid_o,
    input  logic                                   rready_i
);

    typedef enum logic {IDLE, BURST} state_t;

    state_t                state_q, state_d;
    logic [LOG_N_INIT-1:0] rr_ptr_q, rr_ptr_d, grant_q, grant_d;
    logic [LOG_N_INIT-1:0] sel, g, g_next;
    logic                  any_valid, slot_free, accept, out_valid_q;
    logic [LOG_N_TARG-1:0] unused_tgt_bits;

    // Target-index bits only steer routing upstream; they are dropped here.
    always_comb begin
        unused_tgt_bits = '0;
        for (int i = 0; i < N_INIT_PORT; i++)
            unused_tgt_bits = unused_tgt_bits ^ rid_i[i][AXI_ID_OUT-1:AXI_ID_IN];
    end

    // Round-robin pick: lowest valid port at or above rr_ptr, else lowest valid overall.
    always_comb begin
        sel       = '0;
        any_valid = 1'b0;
        for (int i = N_INIT_PORT - 1; i >= 0; i--) begin
            if (rvalid_i[i]) begin
                sel       = LOG_N_INIT'(i);
                any_valid = 1'b1;
            end
        end
        for (int i = N_INIT_PORT - 1; i >= 0; i--) begin
            if (rvalid_i[i] && i >= int'(rr_ptr_q))
                sel = LOG_N_INIT'(i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        grant_d   = grant_q;
        rready_o  = '0;
        slot_free = ~out_valid_q | rready_i;
        g         = (state_q == BURST) ? grant_q : sel;
        g_next    = (g == LOG_N_INIT'(N_INIT_PORT - 1)) ? '0 : g + 1'b1;
        if (((state_q == BURST) || any_valid) && slot_free && !rst)
            rready_o[g] = 1'b1;
        accept = rvalid_i[g] & rready_o[g];
        if (accept) begin
            if (rlast_i[g]) begin
                state_d  = IDLE;
                rr_ptr_d = g_next;
            end else begin
                state_d = BURST;
                grant_d = g;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            rid_o       <= '0;
            rdata_o     <= '0;
            rresp_o     <= '0;
            rlast_o     <= 1'b0;
            ruser_o     <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            rid_o       <= rid_i[g][AXI_ID_IN-1:0];
            rdata_o     <= rdata_i[g];
            rresp_o     <= rresp_i[g];
            rlast_o     <= rlast_i[g];
            ruser_o     <= ruser_i[g];
        end else if (rready_i) begin
            out_valid_q <= 1'b0;
        end
    end

    assign rvalid_o = out_valid_q;

endmodule

// File: tb/tb_axi_r_burst_allocator.sv
// tb/tb_axi_r_burst_allocator.sv - directed scenario bench for axi_r_burst_allocator
// Slave ports are scripted beat sources; outputs sampled on the falling edge.
module tb_axi_r_burst_allocator;

    localparam int N   = 5;
    localparam int DW  = 64;
    localparam int UW  = 6;
    localparam int IDI = 16;
    localparam int IDO = 19;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [N-1:0][IDO-1:0]   rid_i;
    logic [N-1:0][DW-1:0]    rdata_i;
    logic [N-1:0][1:0]       rresp_i;
    logic [N-1:0]            rlast_i;
    logic [N-1:0][UW-1:0]    ruser_i;
    logic [N-1:0]            rvalid_i;
    logic [N-1:0]            rready_o;
    logic [IDI-1:0]          rid_o;
    logic [DW-1:0]           rdata_o;
    logic [1:0]              rresp_o;
    logic                    rlast_o;
    logic [UW-1:0]           ruser_o;
    logic                    rvalid_o;
    logic                    rready_i = 1'b1;

    axi_r_burst_allocator #(
        .AXI_DATA_W(DW), .AXI_USER_W(UW), .N_INIT_PORT(N), .AXI_ID_IN(IDI), .LOG_N_TARG(3)
    ) dut (
        .clk(clk), .rst(rst), .rid_i(rid_i), .rdata_i(rdata_i), .rresp_i(rresp_i),
        .rlast_i(rlast_i), .ruser_i(ruser_i), .rvalid_i(rvalid_i), .rready_o(rready_o),
        .rid_o(rid_o), .rdata_o(rdata_o), .rresp_o(rresp_o), .rlast_o(rlast_o),
        .ruser_o(ruser_o), .rvalid_o(rvalid_o), .rready_i(rready_i)
    );

    always #5 clk = ~clk;

    int            len[N], beat[N], bursts[N];
    bit            act[N], rpt[N];
    logic [IDO-1:0] idv[N];
    logic [N-1:0]  acc;
    logic [DW-1:0] out_data[$];
    logic          out_last[$];
    logic [IDI-1:0] out_id[$];
    logic [N-1:0]  rdy_log[$];
    logic          vld_log[$];
    logic [DW-1:0] data_log[$];
    int            total = 0;
    int            bad = 0;

    function automatic logic [DW-1:0] mk(input int p, input int b, input int n);
        return (64'(p) << 16) | (64'(b) << 8) | 64'(n);
    endfunction

    task automatic drive();
        for (int p = 0; p < N; p++) begin
            rvalid_i[p] = act[p] && (beat[p] < len[p]);
            rdata_i[p]  = mk(p, bursts[p], beat[p]);
            rlast_i[p]  = (beat[p] == len[p] - 1);
            rresp_i[p]  = 2'(p);
            ruser_i[p]  = UW'(beat[p]);
            rid_i[p]    = idv[p];
        end
    endtask

    task automatic tick();
        @(negedge clk);
        acc = rvalid_i & rready_o;
        rdy_log.push_back(rready_o);
        vld_log.push_back(rvalid_o);
        data_log.push_back(rdata_o);
        if (rvalid_o && rready_i) begin
            out_data.push_back(rdata_o);
            out_last.push_back(rlast_o);
            out_id.push_back(rid_o);
        end
        @(posedge clk);
        #1;
        for (int p = 0; p < N; p++) begin
            if (acc[p]) begin
                beat[p]++;
                if (beat[p] >= len[p] && rpt[p]) begin
                    beat[p] = 0;
                    bursts[p]++;
                end
            end
        end
        drive();
    endtask

    task automatic clear_logs();
        out_data.delete(); out_last.delete(); out_id.delete();
        rdy_log.delete(); vld_log.delete(); data_log.delete();
    endtask

    task automatic clear_ports();
        for (int p = 0; p < N; p++) begin
            act[p] = 0; rpt[p] = 0; len[p] = 0; beat[p] = 0; bursts[p] = 0;
            idv[p] = (IDO'(p) << 16) | IDO'(p);
        end
    endtask

    task automatic do_reset();
        clear_ports();
        rready_i = 1'b1;
        rst = 1'b1;
        drive();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic test_reset();
        clear_ports();
        for (int p = 0; p < N; p++) begin act[p] = 1; len[p] = 1; end
        rst = 1'b1;
        drive();
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (rready_o !== 5'b00000) begin bad++; $display("FAIL reset_rready got=%b exp=00000", rready_o); end
        total++;
        if (rvalid_o !== 1'b0) begin bad++; $display("FAIL reset_rvalid got=%b exp=0", rvalid_o); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_logs();
        repeat (6) tick();
        total++;
        if (rdy_log[0] !== 5'b00001) begin bad++; $display("FAIL reset_first_grant got=%b exp=00001", rdy_log[0]); end
        total++;
        if (rdy_log[1] !== 5'b00010) begin bad++; $display("FAIL reset_second_grant got=%b exp=00010", rdy_log[1]); end
        total++;
        if (out_data.size() != 5) begin bad++; $display("FAIL reset_beat_count got=%0d exp=5", out_data.size()); end
        for (int p = 0; p < 5 && p < out_data.size(); p++) begin
            total++;
            if (out_data[p] !== mk(p, 0, 0)) begin bad++; $display("FAIL reset_order[%0d] got=%h exp=%h", p, out_data[p], mk(p, 0, 0)); end
        end
    endtask

    task automatic test_burst_lock();
        do_reset();
        act[1] = 1; len[1] = 4;
        drive();
        tick();
        act[3] = 1; len[3] = 1;
        drive();
        repeat (6) tick();
        for (int i = 0; i < 4; i++) begin
            total++;
            if (rdy_log[i] !== 5'b00010) begin bad++; $display("FAIL lock_rready[%0d] got=%b exp=00010", i, rdy_log[i]); end
        end
        total++;
        if (rdy_log[4] !== 5'b01000) begin bad++; $display("FAIL lock_next_grant got=%b exp=01000", rdy_log[4]); end
        for (int i = 1; i <= 4; i++) begin
            total++;
            if (vld_log[i] !== 1'b1) begin bad++; $display("FAIL lock_b2b_valid[%0d] got=%b exp=1", i, vld_log[i]); end
        end
        total++;
        if (out_data.size() != 5) begin bad++; $display("FAIL lock_beat_count got=%0d exp=5", out_data.size()); end
        for (int i = 0; i < 5 && i < out_data.size(); i++) begin
            total++;
            if (out_data[i] !== ((i < 4) ? mk(1, 0, i) : mk(3, 0, 0))) begin
                bad++; $display("FAIL lock_data[%0d] got=%h exp=%h", i, out_data[i], (i < 4) ? mk(1, 0, i) : mk(3, 0, 0));
            end
        end
        if (out_last.size() >= 4) begin
            total++;
            if (out_last[2] !== 1'b0 || out_last[3] !== 1'b1) begin
                bad++; $display("FAIL lock_rlast got=%b%b exp=01", out_last[2], out_last[3]);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [DW-1:0] exp_rr[6];
        do_reset();
        exp_rr = '{mk(0, 0, 0), mk(2, 0, 0), mk(4, 0, 0), mk(0, 1, 0), mk(2, 1, 0), mk(4, 1, 0)};
        for (int p = 0; p < N; p += 2) begin act[p] = 1; len[p] = 1; rpt[p] = 1; end
        drive();
        repeat (7) tick();
        total++;
        if (rdy_log[2] !== 5'b10000) begin bad++; $display("FAIL rr_grant4 got=%b exp=10000", rdy_log[2]); end
        total++;
        if (rdy_log[3] !== 5'b00001) begin bad++; $display("FAIL rr_wrap got=%b exp=00001", rdy_log[3]); end
        total++;
        if (out_data.size() != 6) begin bad++; $display("FAIL rr_beat_count got=%0d exp=6", out_data.size()); end
        for (int i = 0; i < 6 && i < out_data.size(); i++) begin
            total++;
            if (out_data[i] !== exp_rr[i]) begin bad++; $display("FAIL rr_order[%0d] got=%h exp=%h", i, out_data[i], exp_rr[i]); end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        act[2] = 1; len[2] = 6;
        drive();
        for (int t = 1; t <= 12; t++) begin
            if (t == 3) rready_i = 1'b0;
            if (t == 6) rready_i = 1'b1;
            tick();
        end
        for (int i = 2; i <= 4; i++) begin
            total++;
            if (rdy_log[i] !== 5'b00000 || vld_log[i] !== 1'b1 || data_log[i] !== mk(2, 0, 1)) begin
                bad++; $display("FAIL bp_hold[%0d] got=rdy %b vld %b data %h exp=rdy 00000 vld 1 data %h",
                                i, rdy_log[i], vld_log[i], data_log[i], mk(2, 0, 1));
            end
        end
        for (int i = 5; i <= 9; i++) begin
            total++;
            if (vld_log[i] !== 1'b1) begin bad++; $display("FAIL bp_release_valid[%0d] got=%b exp=1", i, vld_log[i]); end
        end
        total++;
        if (out_data.size() != 6) begin bad++; $display("FAIL bp_beat_count got=%0d exp=6", out_data.size()); end
        for (int i = 0; i < 6 && i < out_data.size(); i++) begin
            total++;
            if (out_data[i] !== mk(2, 0, i) || out_last[i] !== (i == 5)) begin
                bad++; $display("FAIL bp_beat[%0d] got=%h/%b exp=%h/%b", i, out_data[i], out_last[i], mk(2, 0, i), i == 5);
            end
        end
    endtask

    task automatic test_id_strip();
        do_reset();
        idv[2] = 19'h5_ABCD;
        act[2] = 1; len[2] = 1;
        drive();
        repeat (3) tick();
        total++;
        if (out_id.size() != 1) begin
            bad++; $display("FAIL id_beat_count got=%0d exp=1", out_id.size());
        end else if (out_id[0] !== 16'hABCD || out_data[0] !== mk(2, 0, 0)) begin
            bad++; $display("FAIL id_strip got=%h/%h exp=abcd/%h", out_id[0], out_data[0], mk(2, 0, 0));
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        act[0] = 1; len[0] = 8;
        drive();
        repeat (2) tick();
        rst = 1'b1;
        #1;
        total++;
        if (rvalid_o !== 1'b0) begin bad++; $display("FAIL midrst_rvalid got=%b exp=0", rvalid_o); end
        total++;
        if (rready_o !== 5'b00000) begin bad++; $display("FAIL midrst_rready got=%b exp=00000", rready_o); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        act[0] = 0;
        act[1] = 1; len[1] = 1;
        act[3] = 1; len[3] = 1;
        drive();
        clear_logs();
        tick();
        total++;
        if (rdy_log[0] !== 5'b00010) begin bad++; $display("FAIL midrst_idle_rrptr got=%b exp=00010", rdy_log[0]); end
        total++;
        if (vld_log[0] !== 1'b0) begin bad++; $display("FAIL midrst_out_empty got=%b exp=0", vld_log[0]); end
    endtask

    initial begin
        test_reset();
        test_burst_lock();
        test_round_robin();
        test_backpressure();
        test_id_strip();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
